// File: rtl/uart_tx_fifo_pkg.sv
// rtl/uart_tx_fifo_pkg.sv - frame state encoding and parity helper shared by the UART transmitter and receiver
package uart_tx_fifo_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   localparam int MAX_DATA_BITS = 9;

   // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
   function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] word, input logic odd);
      return (^word) ^ odd;
   endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// rtl/uart_tx_fifo_sync_fifo.sv - synchronous FIFO with occupancy level and full/empty flags
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   output logic [WIDTH-1:0]         rd_data,
   input  logic                     rd_en,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push;
   logic             pop;

   assign wr_ready = (level != LW'(DEPTH));
   assign empty    = (level == '0);
   assign push     = wr_valid && wr_ready;
   assign pop      = rd_en && !empty;
   assign rd_data  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter with per-frame parity and stop-bit selection
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int CLK_DIV    = 173,
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic [DATA_BITS-1:0]          i_data,
   input  logic                          i_valid,
   output logic                          o_ready,
   input  logic                          i_parity_en,
   input  logic                          i_parity_odd,
   input  logic                          i_two_stop,
   output logic                          o_tx,
   output logic                          o_busy,
   output logic [$clog2(FIFO_DEPTH):0]   o_level
);
   localparam logic [15:0] BAUD_LOAD = 16'(CLK_DIV - 1);
   localparam logic [3:0]  LAST_BIT  = 4'(DATA_BITS - 1);

   tx_state_t            state, state_next;
   logic [15:0]          baud_cnt, baud_next;
   logic [3:0]           bit_cnt, bit_next;
   logic [DATA_BITS-1:0] shift, shift_next, head;
   logic                 tx, tx_next;
   logic                 parity_en, two_stop, par_bit;
   logic                 empty, pop, start_frame, tick;

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .wr_data  (i_data),
      .wr_valid (i_valid),
      .wr_ready (o_ready),
      .rd_data  (head),
      .rd_en    (pop),
      .empty    (empty),
      .level    (o_level)
   );

   assign tick   = (baud_cnt == 16'd0);
   assign o_tx   = tx;
   assign o_busy = (state != ST_IDLE) || (o_level != '0);

   always_comb begin
      state_next  = state;
      baud_next   = tick ? BAUD_LOAD : baud_cnt - 16'd1;
      bit_next    = bit_cnt;
      shift_next  = shift;
      tx_next     = tx;
      start_frame = 1'b0;
      case (state)
         ST_IDLE: begin
            baud_next = '0;
            tx_next   = 1'b1;
            if (!empty) start_frame = 1'b1;
         end
         ST_START: if (tick) begin
            state_next = ST_DATA;
            bit_next   = '0;
            tx_next    = shift[0];
         end
         ST_DATA: if (tick) begin
            if (bit_cnt == LAST_BIT) begin
               bit_next = '0;
               if (parity_en) begin
                  state_next = ST_PARITY;
                  tx_next    = par_bit;
               end else begin
                  state_next = ST_STOP;
                  tx_next    = 1'b1;
               end
            end else begin
               bit_next   = bit_cnt + 4'd1;
               shift_next = shift >> 1;
               tx_next    = shift[1];
            end
         end
         ST_PARITY: if (tick) begin
            state_next = ST_STOP;
            bit_next   = '0;
            tx_next    = 1'b1;
         end
         ST_STOP: if (tick) begin
            if (two_stop && bit_cnt == 4'd0) bit_next = 4'd1;
            else if (!empty)                 start_frame = 1'b1;
            else                             state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
      // A new frame starts straight from IDLE or from the last stop cycle, so frames abut.
      if (start_frame) begin
         state_next = ST_START;
         baud_next  = BAUD_LOAD;
         shift_next = head;
         tx_next    = 1'b0;
      end
   end

   assign pop = start_frame;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= ST_IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         tx        <= 1'b1;
         parity_en <= 1'b0;
         two_stop  <= 1'b0;
         par_bit   <= 1'b0;
      end else begin
         state    <= state_next;
         baud_cnt <= baud_next;
         bit_cnt  <= bit_next;
         shift    <= shift_next;
         tx       <= tx_next;
         if (start_frame) begin
            parity_en <= i_parity_en;
            two_stop  <= i_two_stop;
            par_bit   <= parity_of(MAX_DATA_BITS'(head), i_parity_odd);
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

   logic       clk;
   logic       rst_n;
   logic [7:0] a_data;
   logic       a_valid, a_ready, a_par_en, a_par_odd, a_two, a_tx, a_busy;
   logic [2:0] a_level;
   logic [4:0] b_data;
   logic       b_valid, b_ready, b_tx, b_busy;
   logic [1:0] b_level;

   int checks   = 0;
   int failures = 0;

   uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .FIFO_DEPTH(4)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(a_data), .i_valid(a_valid), .o_ready(a_ready),
      .i_parity_en(a_par_en), .i_parity_odd(a_par_odd), .i_two_stop(a_two),
      .o_tx(a_tx), .o_busy(a_busy), .o_level(a_level)
   );

   uart_tx_fifo #(.CLK_DIV(2), .DATA_BITS(5), .FIFO_DEPTH(2)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(b_data), .i_valid(b_valid), .o_ready(b_ready),
      .i_parity_en(1'b0), .i_parity_odd(1'b0), .i_two_stop(1'b0),
      .o_tx(b_tx), .o_busy(b_busy), .o_level(b_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push_a(input logic [7:0] d);
      @(negedge clk);
      a_data  = d;
      a_valid = 1'b1;
      @(posedge clk);
      #1;
      a_valid = 1'b0;
   endtask

   task automatic push_b(input logic [4:0] d);
      @(negedge clk);
      b_data  = d;
      b_valid = 1'b1;
      @(posedge clk);
      #1;
      b_valid = 1'b0;
   endtask

   // Samples one bit per div cycles; bits[i] is the first sample of bit i.
   task automatic capture(input bit sel, input int nbits, input int div,
                          output logic [15:0] bits, output int glitches);
      logic s;
      bits     = '0;
      glitches = 0;
      for (int i = 0; i < nbits; i++) begin
         for (int c = 0; c < div; c++) begin
            @(negedge clk);
            s = sel ? b_tx : a_tx;
            if (c == 0) bits[i] = s;
            else if (s !== bits[i]) glitches++;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      a_valid = 1'b0; a_data = '0; a_par_en = 1'b0; a_par_odd = 1'b0; a_two = 1'b0;
      b_valid = 1'b0; b_data = '0;
      repeat (3) @(negedge clk);
      checks++; if (a_tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b want=1", a_tx); end
      checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", a_busy); end
      checks++; if (a_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d want=0", a_level); end
      checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", a_ready); end
      checks++; if (b_tx !== 1'b1) begin failures++; $display("FAIL reset_b_tx got=%b want=1", b_tx); end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (a_tx !== 1'b1 || a_busy !== 1'b0) begin failures++; $display("FAIL idle_after_reset tx=%b busy=%b want tx=1 busy=0", a_tx, a_busy); end
   endtask

   task automatic test_single_byte;
      logic [15:0] bits;
      int          g;
      push_a(8'h41);
      checks++; if (a_tx !== 1'b1) begin failures++; $display("FAIL latency_pre got=%b want=1", a_tx); end
      checks++; if (a_level !== 3'd1) begin failures++; $display("FAIL push_level got=%0d want=1", a_level); end
      @(posedge clk); #1;
      checks++; if (a_tx !== 1'b0) begin failures++; $display("FAIL start_latency got=%b want=0", a_tx); end
      capture(1'b0, 10, 4, bits, g);
      checks++; if (bits[9:0] !== 10'h282) begin failures++; $display("FAIL frame_41 got=%h want=282", bits[9:0]); end
      checks++; if (g !== 0) begin failures++; $display("FAIL bit_width_41 got=%0d want=0", g); end
      checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL busy_cycle40 got=%b want=1", a_busy); end
      @(negedge clk);
      checks++; if (a_busy !== 1'b0 || a_tx !== 1'b1) begin failures++; $display("FAIL busy_cycle41 busy=%b tx=%b want busy=0 tx=1", a_busy, a_tx); end
   endtask

   task automatic test_parity;
      logic [15:0] bits;
      int          g;
      logic [15:0] expect_fr [2] = '{16'h0406, 16'h0606};
      for (int odd = 0; odd < 2; odd++) begin
         a_par_en = 1'b1; a_par_odd = odd[0]; a_two = 1'b0;
         push_a(8'h03);
         @(posedge clk); #1;
         capture(1'b0, 11, 4, bits, g);
         checks++; if (bits[10:0] !== expect_fr[odd][10:0] || g !== 0) begin
            failures++; $display("FAIL parity_frame odd=%0d got=%h glitches=%0d want=%h", odd, bits[10:0], g, expect_fr[odd][10:0]);
         end
         @(negedge clk);
         checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL parity_len odd=%0d busy=%b want=0", odd, a_busy); end
      end
   endtask

   task automatic test_two_stop;
      logic [15:0] bits;
      int          g;
      a_par_en = 1'b1; a_par_odd = 1'b0; a_two = 1'b1;
      push_a(8'h03);
      @(posedge clk); #1;
      a_par_en = 1'b0; a_par_odd = 1'b1; a_two = 1'b0;
      capture(1'b0, 12, 4, bits, g);
      checks++; if (bits[11:0] !== 12'hC06 || g !== 0) begin
         failures++; $display("FAIL two_stop_frame got=%h glitches=%0d want=c06", bits[11:0], g);
      end
      checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL two_stop_cycle48 busy=%b want=1", a_busy); end
      @(negedge clk);
      checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL two_stop_cycle49 busy=%b want=0", a_busy); end
      a_par_odd = 1'b0;
   endtask

   task automatic test_fill_overflow;
      logic [7:0]  w [6]         = '{8'hA5, 8'h3C, 8'hF0, 8'h0F, 8'h81, 8'h77};
      logic [2:0]  expect_lvl [6] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
      logic        expect_rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [15:0] fr [5];
      int          gl [5];
      @(negedge clk);
      fork
         begin
            for (int k = 0; k < 6; k++) begin
               checks++; if (a_level !== expect_lvl[k] || a_ready !== expect_rdy[k]) begin
                  failures++; $display("FAIL fill_k%0d level=%0d ready=%b want level=%0d ready=%b", k, a_level, a_ready, expect_lvl[k], expect_rdy[k]);
               end
               a_data  = w[k];
               a_valid = 1'b1;
               @(negedge clk);
            end
            a_valid = 1'b0;
         end
         begin
            repeat (2) @(posedge clk);
            for (int f = 0; f < 5; f++) capture(1'b0, 10, 4, fr[f], gl[f]);
         end
      join
      for (int f = 0; f < 5; f++) begin
         checks++; if (fr[f][9:0] !== {1'b1, w[f], 1'b0} || gl[f] !== 0) begin
            failures++; $display("FAIL fill_frame%0d got=%h glitches=%0d want=%h", f, fr[f][9:0], gl[f], {1'b1, w[f], 1'b0});
         end
      end
      @(negedge clk);
      checks++; if (a_busy !== 1'b0 || a_level !== 3'd0) begin
         failures++; $display("FAIL fill_drain busy=%b level=%0d want busy=0 level=0", a_busy, a_level);
      end
   endtask

   task automatic test_push_pop_full;
      logic [7:0]  w [6] = '{8'hA5, 8'h3C, 8'hF0, 8'h0F, 8'h81, 8'h5A};
      logic [15:0] fr [6];
      int          gl [6];
      @(negedge clk);
      fork
         begin
            for (int k = 0; k <= 43; k++) begin
               if (k == 5) begin
                  checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b want=0", a_ready); end
               end
               if (k == 41) begin
                  checks++; if (a_ready !== 1'b0 || a_level !== 3'd4) begin
                     failures++; $display("FAIL pre_pop ready=%b level=%0d want ready=0 level=4", a_ready, a_level);
                  end
               end
               if (k == 42) begin
                  checks++; if (a_ready !== 1'b1 || a_level !== 3'd3) begin
                     failures++; $display("FAIL after_pop ready=%b level=%0d want ready=1 level=3", a_ready, a_level);
                  end
               end
               if (k == 43) begin
                  checks++; if (a_ready !== 1'b0 || a_level !== 3'd4) begin
                     failures++; $display("FAIL refill ready=%b level=%0d want ready=0 level=4", a_ready, a_level);
                  end
               end
               a_data  = (k < 5) ? w[k] : w[5];
               a_valid = (k < 43);
               @(negedge clk);
            end
         end
         begin
            repeat (2) @(posedge clk);
            for (int f = 0; f < 6; f++) capture(1'b0, 10, 4, fr[f], gl[f]);
         end
      join
      for (int f = 0; f < 6; f++) begin
         checks++; if (fr[f][9:0] !== {1'b1, w[f], 1'b0} || gl[f] !== 0) begin
            failures++; $display("FAIL full_frame%0d got=%h glitches=%0d want=%h", f, fr[f][9:0], gl[f], {1'b1, w[f], 1'b0});
         end
      end
      @(negedge clk);
      checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL full_drain busy=%b want=0", a_busy); end
   endtask

   task automatic test_five_bits;
      logic [15:0] bits;
      int          g;
      push_b(5'h1F);
      @(posedge clk); #1;
      checks++; if (b_tx !== 1'b0) begin failures++; $display("FAIL b_start got=%b want=0", b_tx); end
      capture(1'b1, 7, 2, bits, g);
      checks++; if (bits[6:0] !== 7'h7E || g !== 0) begin
         failures++; $display("FAIL b_frame got=%h glitches=%0d want=7e", bits[6:0], g);
      end
      checks++; if (b_busy !== 1'b1) begin failures++; $display("FAIL b_cycle14 busy=%b want=1", b_busy); end
      @(negedge clk);
      checks++; if (b_busy !== 1'b0 || b_tx !== 1'b1) begin
         failures++; $display("FAIL b_cycle15 busy=%b tx=%b want busy=0 tx=1", b_busy, b_tx);
      end
   endtask

   task automatic test_reset_mid_frame;
      int bad = 0;
      push_a(8'h41);
      push_a(8'h42);
      push_a(8'h43);
      repeat (12) @(negedge clk);
      checks++; if (a_tx !== 1'b0 || a_level !== 3'd2) begin
         failures++; $display("FAIL pre_reset tx=%b level=%0d want tx=0 level=2", a_tx, a_level);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (a_tx !== 1'b1 || a_level !== 3'd0 || a_busy !== 1'b0) begin
         failures++; $display("FAIL async_reset tx=%b level=%0d busy=%b want tx=1 level=0 busy=0", a_tx, a_level, a_busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (a_tx !== 1'b1 || a_busy !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL post_reset_idle bad_cycles=%0d want=0", bad); end
   endtask

   initial begin
      test_reset;
      test_single_byte;
      test_parity;
      test_two_stop;
      test_fill_overflow;
      test_push_pop_full;
      test_five_bits;
      test_reset_mid_frame;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
